// File: rtl/rle_pkg.sv
// rtl/rle_pkg.sv - shared types, constants and pair-field helpers for the RLE decoder
//
// Purpose : decoder FSM state encoding, word/pair byte counts and the bit
//           positions of (count, byte) fields inside a compressed 32-bit word.
// Ports   : none (package).
package rle_pkg;

  typedef enum logic [3:0] {
    IDLE,
    RD_ADDR,
    RD_DATA,
    LOAD,
    EXPAND,
    WR,
    NEXT,
    FLUSH,
    FINISH
  } state_e;

  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned PAIR_BYTES = 2;

  // pair0 = {byte[15:8], count[7:0]}, pair1 = {byte[31:24], count[23:16]}
  localparam int unsigned PAIR0_CNT_LSB  = 0;
  localparam int unsigned PAIR0_BYTE_LSB = 8;
  localparam int unsigned PAIR1_CNT_LSB  = 16;
  localparam int unsigned PAIR1_BYTE_LSB = 24;

  function automatic logic [7:0] pair_count(input logic [31:0] w, input logic sel);
    return sel ? w[PAIR1_CNT_LSB +: 8] : w[PAIR0_CNT_LSB +: 8];
  endfunction

  function automatic logic [7:0] pair_byte(input logic [31:0] w, input logic sel);
    return sel ? w[PAIR1_BYTE_LSB +: 8] : w[PAIR0_BYTE_LSB +: 8];
  endfunction

endpackage

// File: rtl/rle_byte_packer.sv
// rtl/rle_byte_packer.sv - little-endian byte-to-word packer
//
// Purpose : accumulates bytes into a 32-bit word, first byte in [7:0].
// Ports   : clk, nreset      - clock, async active-low reset
//           clear_i          - empty the word and return to lane 0 (wins over byte_valid_i)
//           byte_valid_i     - store byte_i into the current lane and advance
//           byte_i           - byte to store
//           word_o           - packed word, unused lanes zero
//           lane_o           - next lane to be written
//           full_o           - the next accepted byte completes the word
module rle_byte_packer (
  input  logic        clk,
  input  logic        nreset,
  input  logic        clear_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic [1:0]  lane_o,
  output logic        full_o
);

  logic [31:0] out_buf_q;
  logic [1:0]  lane_q;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      out_buf_q <= '0;
      lane_q    <= '0;
    end else if (clear_i) begin
      out_buf_q <= '0;
      lane_q    <= '0;
    end else if (byte_valid_i) begin
      out_buf_q[{lane_q, 3'b000} +: 8] <= byte_i;
      lane_q                           <= lane_q + 2'd1;
    end
  end

  assign word_o = out_buf_q;
  assign lane_o = lane_q;
  assign full_o = (lane_q == 2'd3);

endmodule

// File: rtl/rle_decode.sv
// rtl/rle_decode.sv - run-length decompressor over a single SRAM port
//
// Purpose : reads (count, byte) pairs from the frame at rle_addr, expands each
//           into count copies of byte, packs them little-endian and writes the
//           words starting at message_addr. Reports length and raises done.
// Ports   : clk, nreset            - clock, async active-low reset
//           start                  - begin decoding (accepted only in IDLE)
//           rle_addr, rle_size     - compressed frame address / length in bytes
//           message_addr           - destination address of the expanded data
//           message_size, done     - expanded byte count, completion flag
//           port_A_*               - SRAM port: clk, addr, we, write data, read data
module rle_decode
  import rle_pkg::*;
(
  input  logic        clk,
  input  logic        nreset,
  input  logic        start,
  input  logic [31:0] rle_addr,
  input  logic [31:0] rle_size,
  input  logic [31:0] message_addr,
  output logic [31:0] message_size,
  output logic        done,
  output logic        port_A_clk,
  output logic [15:0] port_A_addr,
  output logic        port_A_we,
  output logic [31:0] port_A_data_in,
  input  logic [31:0] port_A_data_out
);

  state_e      state_q, state_d;
  logic [31:0] rd_ptr_q, wr_ptr_q, consumed_q, size_q, in_word_q, msg_size_q;
  logic [7:0]  run_rem_q, val_q;
  logic        pair_sel_q, done_q;

  logic [31:0] pk_word;
  logic [1:0]  pk_lane;
  logic        pk_full;

  // An odd trailing byte cannot form a pair, so it is dropped here once.
  logic [31:0] size_even;
  assign size_even = rle_size & ~32'd1;

  logic accept;
  assign accept = (state_q == IDLE) && start;

  logic frame_done;
  assign frame_done = (consumed_q >= size_q);

  rle_byte_packer u_packer (
    .clk          (clk),
    .nreset       (nreset),
    .clear_i      (accept || state_q == WR || state_q == FLUSH),
    .byte_valid_i (state_q == EXPAND),
    .byte_i       (val_q),
    .word_o       (pk_word),
    .lane_o       (pk_lane),
    .full_o       (pk_full)
  );

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = (size_even == 32'd0) ? FINISH : RD_ADDR;
      RD_ADDR: state_d = RD_DATA;
      RD_DATA: state_d = LOAD;
      LOAD:    state_d = (pair_count(in_word_q, pair_sel_q) == 8'd0) ? NEXT : EXPAND;
      // run_rem_q still holds the pre-decrement value while in EXPAND
      EXPAND:  if (pk_full)                state_d = WR;
               else if (run_rem_q == 8'd1) state_d = NEXT;
      WR:      state_d = (run_rem_q != 8'd0) ? EXPAND : NEXT;
      NEXT:    if (frame_done)   state_d = (pk_lane != 2'd0) ? FLUSH : FINISH;
               else if (!pair_sel_q) state_d = LOAD;
               else                  state_d = RD_ADDR;
      FLUSH:   state_d = FINISH;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    port_A_addr    = 16'h0000;
    port_A_we      = 1'b0;
    port_A_data_in = 32'h0000_0000;
    case (state_q)
      RD_ADDR: port_A_addr = rd_ptr_q[15:0];
      WR, FLUSH: begin
        port_A_addr    = wr_ptr_q[15:0];
        port_A_we      = 1'b1;
        port_A_data_in = pk_word;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      consumed_q <= '0;
      size_q     <= '0;
      in_word_q  <= '0;
      msg_size_q <= '0;
      run_rem_q  <= '0;
      val_q      <= '0;
      pair_sel_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          rd_ptr_q   <= rle_addr;
          wr_ptr_q   <= message_addr;
          consumed_q <= '0;
          size_q     <= size_even;
          msg_size_q <= '0;
          done_q     <= 1'b0;
        end
        RD_DATA: begin
          in_word_q  <= port_A_data_out;
          rd_ptr_q   <= rd_ptr_q + 32'(WORD_BYTES);
          pair_sel_q <= 1'b0;
        end
        LOAD: begin
          run_rem_q  <= pair_count(in_word_q, pair_sel_q);
          val_q      <= pair_byte(in_word_q, pair_sel_q);
          consumed_q <= consumed_q + 32'(PAIR_BYTES);
        end
        EXPAND: begin
          run_rem_q  <= run_rem_q - 8'd1;
          msg_size_q <= msg_size_q + 32'd1;
        end
        WR, FLUSH: wr_ptr_q <= wr_ptr_q + 32'(WORD_BYTES);
        NEXT:      if (!frame_done && !pair_sel_q) pair_sel_q <= 1'b1;
        FINISH:    done_q <= 1'b1;
        default: ;
      endcase
    end
  end

  assign message_size = msg_size_q;
  assign done         = done_q;
  assign port_A_clk   = clk;

endmodule

// File: tb/tb_rle_decode.sv
// tb/tb_rle_decode.sv - directed self-checking bench for rle_decode
module tb_rle_decode;

  logic        clk = 1'b0;
  logic        nreset;
  logic        start;
  logic [31:0] rle_addr, rle_size, message_addr;
  logic [31:0] message_size;
  logic        done;
  logic        port_A_clk;
  logic [15:0] port_A_addr;
  logic        port_A_we;
  logic [31:0] port_A_data_in;
  logic [31:0] port_A_data_out;

  always #5 clk = ~clk;

  rle_decode dut (
    .clk             (clk),
    .nreset          (nreset),
    .start           (start),
    .rle_addr        (rle_addr),
    .rle_size        (rle_size),
    .message_addr    (message_addr),
    .message_size    (message_size),
    .done            (done),
    .port_A_clk      (port_A_clk),
    .port_A_addr     (port_A_addr),
    .port_A_we       (port_A_we),
    .port_A_data_in  (port_A_data_in),
    .port_A_data_out (port_A_data_out)
  );

  // SRAM model: synchronous read, one-cycle latency; bench preload port.
  logic [31:0] mem [0:16383];
  logic        tb_we = 1'b0;
  logic [15:0] tb_addr = '0;
  logic [31:0] tb_data = '0;

  logic [15:0] log_addr [0:255];
  logic [31:0] log_data [0:255];
  int          log_n = 0;

  always @(posedge clk) begin
    if (tb_we) mem[tb_addr[15:2]] <= tb_data;
    if (port_A_we) begin
      mem[port_A_addr[15:2]] <= port_A_data_in;
      if (log_n < 256) begin
        log_addr[log_n] <= port_A_addr;
        log_data[log_n] <= port_A_data_in;
      end
      log_n <= log_n + 1;
    end else begin
      port_A_data_out <= mem[port_A_addr[15:2]];
    end
  end

  int n_cmp = 0;
  int n_bad = 0;
  int base;
  logic [31:0] ms1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [15:0] a, input logic [31:0] d);
    @(negedge clk);
    tb_we = 1'b1; tb_addr = a; tb_data = d;
    @(negedge clk);
    tb_we = 1'b0;
  endtask

  task automatic pulse_start(input logic [31:0] ra, input logic [31:0] rs, input logic [31:0] ma);
    @(negedge clk);
    rle_addr = ra; rle_size = rs; message_addr = ma; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run(input string tag, input logic [31:0] ra, input logic [31:0] rs,
                     input logic [31:0] ma);
    base = log_n;
    pulse_start(ra, rs, ma);
    for (int i = 0; i < 3000 && !done; i++) @(negedge clk);
    chk({tag, "_done"}, {31'd0, done}, 32'd1);
  endtask

  task automatic chk_wr(input string tag, input int idx, input logic [15:0] a, input logic [31:0] d);
    chk({tag, "_addr"}, {16'd0, log_addr[idx]}, {16'd0, a});
    chk({tag, "_data"}, log_data[idx], d);
  endtask

  initial begin
    nreset = 1'b0; start = 1'b0;
    rle_addr = '0; rle_size = '0; message_addr = '0;
    repeat (2) @(negedge clk);
    chk("rst_we",   {31'd0, port_A_we}, 32'd0);
    chk("rst_addr", {16'd0, port_A_addr}, 32'd0);
    chk("rst_data", port_A_data_in, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_msz",  message_size, 32'd0);

    poke(16'h0100, 32'h4201_4103);
    poke(16'h0104, 32'h0000_5502);
    poke(16'h0108, 32'h0000_AA06);
    poke(16'h010C, 32'h4302_7700);
    poke(16'h0110, 32'h9903_0201);
    poke(16'h0114, 32'h0000_7704);
    poke(16'h0120, 32'h2202_1101);
    poke(16'h0124, 32'h0000_3303);
    poke(16'h0130, 32'h0000_11C8);
    @(negedge clk);
    nreset = 1'b1;
    @(negedge clk);

    // two runs sharing one output word
    run("t1", 32'h100, 32'd4, 32'h200);
    chk("t1_nwr", log_n - base, 1);
    chk_wr("t1_w0", base, 16'h0200, 32'h4241_4141);
    chk("t1_msz", message_size, 32'd4);
    repeat (5) @(negedge clk);
    chk("t1_done_hold", {31'd0, done}, 32'd1);

    // partial word flushed with zero padding
    run("t2", 32'h104, 32'd2, 32'h300);
    chk("t2_nwr", log_n - base, 1);
    chk_wr("t2_w0", base, 16'h0300, 32'h0000_5555);
    chk("t2_msz", message_size, 32'd2);

    // run crossing a word boundary
    run("t3", 32'h108, 32'd2, 32'h400);
    chk("t3_nwr", log_n - base, 2);
    chk_wr("t3_w0", base, 16'h0400, 32'hAAAA_AAAA);
    chk_wr("t3_w1", base + 1, 16'h0404, 32'h0000_AAAA);
    chk("t3_msz", message_size, 32'd6);

    // zero-count pair skipped
    run("t4", 32'h10C, 32'd4, 32'h500);
    chk("t4_nwr", log_n - base, 1);
    chk_wr("t4_w0", base, 16'h0500, 32'h0000_4343);
    chk("t4_msz", message_size, 32'd2);

    // odd size: trailing byte ignored, only pair0 used
    run("t5", 32'h110, 32'd3, 32'h540);
    chk("t5_nwr", log_n - base, 1);
    chk_wr("t5_w0", base, 16'h0540, 32'h0000_0002);
    chk("t5_msz", message_size, 32'd1);

    // 16-bit address wrap on both pointers
    run("t6", 32'h0001_0114, 32'd2, 32'h0001_FFFC);
    chk("t6_nwr", log_n - base, 1);
    chk_wr("t6_w0", base, 16'hFFFC, 32'h7777_7777);
    chk("t6_msz", message_size, 32'd4);

    // three pairs across two compressed words
    run("t7", 32'h120, 32'd6, 32'h580);
    chk("t7_nwr", log_n - base, 2);
    chk_wr("t7_w0", base, 16'h0580, 32'h3322_2211);
    chk_wr("t7_w1", base + 1, 16'h0584, 32'h0000_3333);
    chk("t7_msz", message_size, 32'd6);

    // empty frame: done two edges after start, no writes
    base = log_n;
    pulse_start(32'h100, 32'd0, 32'h5C0);
    @(negedge clk);
    chk("t8_done", {31'd0, done}, 32'd1);
    chk("t8_nwr", log_n - base, 0);
    chk("t8_msz", message_size, 32'd0);

    // long run: start while busy ignored, then reset mid-expand
    pulse_start(32'h130, 32'd2, 32'h700);
    repeat (30) @(negedge clk);
    ms1 = message_size;
    chk("t9_busy_done", {31'd0, done}, 32'd0);
    pulse_start(32'h100, 32'd4, 32'h600);
    repeat (4) @(negedge clk);
    chk("t9_busy_ignored", {31'd0, (message_size > ms1)}, 32'd1);
    nreset = 1'b0;
    #1;
    chk("t9_rst_we",   {31'd0, port_A_we}, 32'd0);
    chk("t9_rst_addr", {16'd0, port_A_addr}, 32'd0);
    chk("t9_rst_data", port_A_data_in, 32'd0);
    chk("t9_rst_done", {31'd0, done}, 32'd0);
    chk("t9_rst_msz",  message_size, 32'd0);
    base = log_n;
    repeat (3) @(negedge clk);
    chk("t9_rst_nwr", log_n - base, 0);
    nreset = 1'b1;
    @(negedge clk);

    run("t10", 32'h100, 32'd4, 32'h600);
    chk("t10_nwr", log_n - base, 1);
    chk_wr("t10_w0", base, 16'h0600, 32'h4241_4141);
    chk("t10_msz", message_size, 32'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rle_decode.md
Name: rle_decode

Overview:
- Run-length decompressor; the downstream consumer of the compressor's output frame.
- Reads a compressed frame of (count, byte) pairs from the shared dual-port SRAM over port A.
- Expands each pair into `count` copies of `byte`, packs the bytes little-endian into 32-bit words and writes them back to the same SRAM.
- Reports the expanded length and raises done; used for round-trip checking and by the frame consumer.

Parameters:
- None. Fixed widths: 32-bit data/pointers, 16-bit SRAM address, 8-bit run count.

Ports:
- clk  in  1  system clock.
- nreset  in  1  asynchronous, active-low reset.
- start  in  1  begin decoding; sampled only in IDLE.
- rle_addr  in  32  byte address of compressed frame (word aligned).
- rle_size  in  32  compressed length in bytes; even (2 bytes per pair).
- message_addr  in  32  byte address for the expanded output (word aligned).
- message_size  out  32  expanded length in bytes.
- done  out  1  decode complete.
- port_A_clk  out  1  driven directly by clk.
- port_A_addr  out  16  SRAM byte address = low 16 bits of the active pointer.
- port_A_we  out  1  1 = write port_A_data_in at port_A_addr.
- port_A_data_in  out  32  write data (the packed output word).
- port_A_data_out  in  32  read data; valid the cycle after the address is presented with we=0.

Behaviour:
- Compressed word format: pair0 = {byte[15:8], count[7:0]}, pair1 = {byte[31:24], count[23:16]}. Pair0 is consumed first.
- Output packing: first byte in [7:0], then [15:8], [23:16], [31:24].
- Reset values: message_size=0, done=0, port_A_we=0, port_A_addr=0, port_A_data_in=0. State=IDLE. All pointers and counters=0.
- Reset mid-operation aborts immediately. No write is in flight after reset.
- IDLE:
  - done holds its last value.
  - On start: rd_ptr<=rle_addr, wr_ptr<=message_addr, consumed<=0, message_size<=0, lane<=0, out_buf<=0, done<=0.
  - If rle_size==0 go to FINISH, else go to RD_ADDR.
- RD_ADDR: port_A_addr=rd_ptr, we=0. Go to RD_DATA.
- RD_DATA: in_word<=port_A_data_out, rd_ptr+=4, pair_sel<=0. Go to LOAD.
- LOAD:
  - run_rem<=selected count, val<=selected byte, consumed+=2.
  - If count==0 the pair is skipped (go to NEXT).
  - Otherwise go to EXPAND.
- EXPAND, one byte per cycle:
  - out_buf[lane]<=val, lane+=1, run_rem-=1, message_size+=1.
  - If lane==3, go to WR (run_rem is retained).
  - Else if run_rem==1, go to NEXT.
- WR:
  - we=1, addr=wr_ptr, data=out_buf for exactly one cycle.
  - Then wr_ptr+=4, lane<=0, out_buf<=0.
  - If run_rem!=0, return to EXPAND; else go to NEXT.
- NEXT:
  - If consumed>=rle_size: go to FLUSH if lane!=0, else FINISH.
  - Else if pair_sel==0: pair_sel<=1, go to LOAD.
  - Else go to RD_ADDR.
- FLUSH: write the partial word with unused upper lanes zero (one we cycle), wr_ptr+=4. Go to FINISH.
- FINISH: done<=1, go to IDLE. done stays high until the next accepted start.
- Boundaries:
  - Runs cross output word boundaries freely.
  - An odd rle_size is treated as rle_size rounded down; its trailing byte is ignored.
  - start while busy is ignored.
  - Address arithmetic wraps modulo 2^16 on port_A_addr.
  - message_size is a 32-bit count and never wraps within legal frame sizes.
- Read and write never occur in the same cycle (single port). we is asserted only in WR and FLUSH.

Decomposition:
- rle_pkg holds:
  - state enum {IDLE, RD_ADDR, RD_DATA, LOAD, EXPAND, WR, NEXT, FLUSH, FINISH};
  - constants WORD_BYTES=4, PAIR_BYTES=2;
  - field bit positions for count/byte in each pair.
- One natural sub-module, rle_byte_packer. It holds out_buf and lane, with byte-in/clear inputs and a full flag; the same block is reusable by the compressor's writer.

Test Plan:
- rle_size=4, word 0x42014103 -> one write 0x42414141; message_size=4, done=1.
- rle_size=2, word 0x00005502 -> one write 0x00005555 (zero-padded flush); message_size=2.
- rle_size=2, pair (0xAA, 6) -> writes 0xAAAAAAAA then 0x0000AAAA at message_addr+4; message_size=6.
- rle_size=4, word 0x43027700 (pair0 count 0) -> pair0 skipped; single write 0x00004343; message_size=2.
- rle_size=0 with start -> done=1 within 2 cycles, no we pulses, message_size=0.
- nreset asserted during EXPAND of (0x11, 200) -> outputs return to reset values immediately, we=0; a fresh start then decodes correctly.
